ts_sym_buf_sched: RTL and testbench

//  Scheduler for the 10-bit-symbol packing buffer (3 symbols per 32-bit word, multi-cycle ops).

---
 rtl/ts_sym_buf_sched_pkg.sv | 36 +++
 rtl/ts_slot_ptr.sv | 35 +++
 rtl/ts_sym_buf_sched.sv | 185 ++++++++++++++++++
 tb/tb_ts_sym_buf_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_sym_buf_sched_pkg.sv
// Shared definitions for the 10-bit symbol packing-buffer scheduler.
// Holds buffer geometry, op latencies, FSM state encoding, grant
// identifiers and a helper that turns an op length into a busy-counter load.
package ts_sym_buf_sched_pkg;

    localparam int DEPTH_WORDS  = 21;
    localparam int SYM_PER_WORD = 3;
    localparam int WR_OP_CYCLES = 2;
    localparam int RD_OP_CYCLES = 3;
    localparam int CAPACITY     = DEPTH_WORDS * SYM_PER_WORD;

    localparam int SYM_W  = 10;
    localparam int CNT_W  = 7;
    localparam int WORD_W = 5;
    localparam int SLOT_W = 2;
    localparam int BUSY_W = 2;

    localparam logic [BUSY_W-1:0] BUSY_ZERO = {BUSY_W{1'b0}};
    localparam logic [BUSY_W-1:0] BUSY_ONE  = {{(BUSY_W-1){1'b0}}, 1'b1};

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2,
        ST_REWIND  = 2'd3
    } state_t;

    // The busy counter counts down to zero; zero marks the final busy cycle.
    function automatic logic [BUSY_W-1:0] busy_load(input int cycles);
        return BUSY_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ts_slot_ptr.sv
// Slot/word pointer for the packed buffer.
// The slot walks 0..SYM_PER_WORD-1; wrapping the slot bumps the word pointer.
// Ports: CLOCK, RESET (async, active-high), advance (step one symbol),
//        clear (rewind to 0/0, wins over advance), word (word pointer out).
module ts_slot_ptr
    import ts_sym_buf_sched_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              advance,
    input  logic              clear,
    output logic [WORD_W-1:0] word
);

    logic [SLOT_W-1:0] slot_r;

    // Slot and word pointer update.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            slot_r <= {SLOT_W{1'b0}};
            word   <= {WORD_W{1'b0}};
        end else if (clear) begin
            slot_r <= {SLOT_W{1'b0}};
            word   <= {WORD_W{1'b0}};
        end else if (advance) begin
            if (slot_r == SLOT_W'(SYM_PER_WORD - 1)) begin
                slot_r <= {SLOT_W{1'b0}};
                word   <= word + 5'd1;
            end else begin
                slot_r <= slot_r + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ts_sym_buf_sched.sv
// Scheduler for the 10-bit-symbol packing buffer (3 symbols per 32-bit word).
// Arbitrates between the TS writer and the reader, keeps one buffer op in
// flight, issues BUF_WRITE/BUF_READ/BUF_RESET pulses and rewinds the
// non-wrapping buffer once every slot has been written and drained.
// Ports: CLOCK/RESET; IN_VALID/IN_DATA/IN_READY writer side (IN_READY is
// combinational); OUT_VALID/OUT_DATA/OUT_READY reader side; BUF_* buffer
// command/data; COUNT, WR_WORD, RD_WORD, FULL, EMPTY status.
module ts_sym_buf_sched
    import ts_sym_buf_sched_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IN_VALID,
    input  logic [SYM_W-1:0]  IN_DATA,
    output logic              IN_READY,
    output logic              OUT_VALID,
    output logic [SYM_W-1:0]  OUT_DATA,
    input  logic              OUT_READY,
    output logic              BUF_WRITE,
    output logic              BUF_READ,
    output logic              BUF_RESET,
    output logic [SYM_W-1:0]  BUF_DATA_IN,
    input  logic [SYM_W-1:0]  BUF_DATA_OUT,
    output logic [CNT_W-1:0]  COUNT,
    output logic [WORD_W-1:0] WR_WORD,
    output logic [WORD_W-1:0] RD_WORD,
    output logic              FULL,
    output logic              EMPTY
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BUSY_W-1:0]  busy_r;
    logic               last_grant_r;
    logic [CNT_W-1:0]   count_r;
    logic               out_valid_r;
    logic [SYM_W-1:0]   out_data_r;
    logic               buf_write_r;
    logic               buf_read_r;
    logic               buf_reset_r;
    logic [SYM_W-1:0]   buf_data_in_r;
    logic               grant_wr_s;
    logic               grant_rd_s;
    logic               rewind_s;
    logic               wr_ok_s;
    logic               rd_ok_s;
    logic               full_s;
    logic               empty_s;
    logic               read_done_s;

    // FULL means every slot has been written since the last rewind, not
    // that COUNT reached capacity: the buffer does not wrap.
    assign full_s      = (WR_WORD == WORD_W'(DEPTH_WORDS));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign wr_ok_s     = IN_VALID & ~full_s;
    assign rd_ok_s     = ~empty_s & ~out_valid_r;
    assign read_done_s = (state_r == ST_RD_BUSY) && (busy_r == BUSY_ZERO);

    assign IN_READY    = grant_wr_s;
    assign OUT_VALID   = out_valid_r;
    assign OUT_DATA    = out_data_r;
    assign BUF_WRITE   = buf_write_r;
    assign BUF_READ    = buf_read_r;
    assign BUF_RESET   = buf_reset_r;
    assign BUF_DATA_IN = buf_data_in_r;
    assign COUNT       = count_r;
    assign FULL        = full_s;
    assign EMPTY       = empty_s;

    // Write pointer: one slot per granted write, cleared on rewind.
    ts_slot_ptr u_wr_ptr (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .advance (grant_wr_s),
        .clear   (rewind_s),
        .word    (WR_WORD)
    );

    // Read pointer: one slot per granted read, cleared on rewind.
    ts_slot_ptr u_rd_ptr (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .advance (grant_rd_s),
        .clear   (rewind_s),
        .word    (RD_WORD)
    );

    // FSM state register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and grant decode; rewind outranks any grant.
    always_comb begin
        state_nxt_s = state_r;
        grant_wr_s  = 1'b0;
        grant_rd_s  = 1'b0;
        rewind_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (full_s && empty_s) begin
                    rewind_s    = 1'b1;
                    state_nxt_s = ST_REWIND;
                end else if (wr_ok_s && rd_ok_s) begin
                    // Contention: alternate, starting with a write after reset.
                    if (last_grant_r == GRANT_RD) begin
                        grant_wr_s  = 1'b1;
                        state_nxt_s = ST_WR_BUSY;
                    end else begin
                        grant_rd_s  = 1'b1;
                        state_nxt_s = ST_RD_BUSY;
                    end
                end else if (wr_ok_s) begin
                    grant_wr_s  = 1'b1;
                    state_nxt_s = ST_WR_BUSY;
                end else if (rd_ok_s) begin
                    grant_rd_s  = 1'b1;
                    state_nxt_s = ST_RD_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_BUSY, ST_RD_BUSY: begin
                if (busy_r == BUSY_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_REWIND: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Buffer command pulses, occupancy, busy timing and reader output stage.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            busy_r        <= BUSY_ZERO;
            last_grant_r  <= GRANT_RD;
            count_r       <= {CNT_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_data_r    <= {SYM_W{1'b0}};
            buf_write_r   <= 1'b0;
            buf_read_r    <= 1'b0;
            buf_reset_r   <= 1'b0;
            buf_data_in_r <= {SYM_W{1'b0}};
        end else begin
            buf_write_r <= grant_wr_s;
            buf_read_r  <= grant_rd_s;
            buf_reset_r <= rewind_s;

            if (grant_wr_s) begin
                // BUF_DATA_IN keeps this symbol until the next write grant.
                buf_data_in_r <= IN_DATA;
                count_r       <= count_r + 7'd1;
                busy_r        <= busy_load(WR_OP_CYCLES);
                last_grant_r  <= GRANT_WR;
            end else if (grant_rd_s) begin
                count_r       <= count_r - 7'd1;
                busy_r        <= busy_load(RD_OP_CYCLES);
                last_grant_r  <= GRANT_RD;
            end else if (busy_r != BUSY_ZERO) begin
                busy_r        <= busy_r - BUSY_ONE;
            end

            // Capture and handshake never coincide: a read is only granted
            // while OUT_VALID is low.
            if (read_done_s) begin
                out_data_r  <= BUF_DATA_OUT;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && OUT_READY) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ts_sym_buf_sched.sv
// Self-checking bench for ts_sym_buf_sched: a buffer model answers BUF_READ,
// a scoreboard tracks accepted symbols through BUF_WRITE and the reader port,
// a table of burst vectors checks end state, and hand-written sequences cover
// first-write latency, grant alternation, read latency, fill, drain/rewind
// and reset during a read.
module tb_ts_sym_buf_sched;
    import ts_sym_buf_sched_pkg::*;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b1;
    logic              IN_VALID = 1'b0;
    logic [SYM_W-1:0]  IN_DATA = 10'h000;
    logic              OUT_READY = 1'b0;
    logic [SYM_W-1:0]  BUF_DATA_OUT = 10'h000;
    logic              IN_READY;
    logic              OUT_VALID;
    logic [SYM_W-1:0]  OUT_DATA;
    logic              BUF_WRITE;
    logic              BUF_READ;
    logic              BUF_RESET;
    logic [SYM_W-1:0]  BUF_DATA_IN;
    logic [CNT_W-1:0]  COUNT;
    logic [WORD_W-1:0] WR_WORD;
    logic [WORD_W-1:0] RD_WORD;
    logic              FULL;
    logic              EMPTY;

    ts_sym_buf_sched dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .IN_VALID     (IN_VALID),
        .IN_DATA      (IN_DATA),
        .IN_READY     (IN_READY),
        .OUT_VALID    (OUT_VALID),
        .OUT_DATA     (OUT_DATA),
        .OUT_READY    (OUT_READY),
        .BUF_WRITE    (BUF_WRITE),
        .BUF_READ     (BUF_READ),
        .BUF_RESET    (BUF_RESET),
        .BUF_DATA_IN  (BUF_DATA_IN),
        .BUF_DATA_OUT (BUF_DATA_OUT),
        .COUNT        (COUNT),
        .WR_WORD      (WR_WORD),
        .RD_WORD      (RD_WORD),
        .FULL         (FULL),
        .EMPTY        (EMPTY)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / buffer model ----------------
    logic [SYM_W-1:0] wq[$];
    logic [SYM_W-1:0] oq[$];
    logic [SYM_W-1:0] mem [0:CAPACITY-1];
    int               wi = 0;
    int               ri = 0;
    int               mcnt = 0;
    int               since = 100;
    bit               last_rd = 1'b0;
    int               rst_pulses = 0;
    bit               alt_on = 1'b0;
    int               alt_pulses = 0;
    bit               alt_last_rd = 1'b0;
    bit               prev_ov = 1'b0;
    bit               prev_hs = 1'b0;
    logic [SYM_W-1:0] prev_od = 10'h000;
    logic [SYM_W-1:0] exp_sym;
    logic [CNT_W-1:0] exp_cnt;
    logic [WORD_W-1:0] exp_ww;
    logic [WORD_W-1:0] exp_rw;

    task automatic pulse_check(input bit is_rd);
        int need;
        need = last_rd ? (RD_OP_CYCLES + 1) : (WR_OP_CYCLES + 1);
        checks++;
        if (since < need) begin
            errors++;
            $display("FAIL busy_window gap=%0d required_min=%0d", since, need);
        end
        if (alt_on) begin
            if (alt_pulses > 0) chk("alternate_grant", is_rd, !alt_last_rd);
            alt_last_rd = is_rd;
            alt_pulses++;
        end
        last_rd = is_rd;
        since   = 0;
    endtask

    always @(negedge CLOCK) begin
        if (RESET) begin
            wq.delete();
            oq.delete();
            wi = 0; ri = 0; mcnt = 0; since = 100; last_rd = 1'b0;
            prev_ov = 1'b0; prev_hs = 1'b0;
            BUF_DATA_OUT = 10'h000;
        end else begin
            since++;
            if (IN_READY) begin
                chk("in_ready_without_valid", IN_VALID, 1'b1);
                wq.push_back(IN_DATA);
                oq.push_back(IN_DATA);
            end
            if (BUF_WRITE) begin
                pulse_check(1'b0);
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL buf_write_unexpected data=0x%0h", BUF_DATA_IN);
                end else begin
                    exp_sym = wq.pop_front();
                    chk("buf_data_in", BUF_DATA_IN, exp_sym);
                    if (wi < CAPACITY) mem[wi] = exp_sym;
                    wi++;
                    mcnt++;
                end
            end
            if (BUF_READ) begin
                pulse_check(1'b1);
                chk("read_while_out_valid", prev_ov, 1'b0);
                if (ri < CAPACITY) BUF_DATA_OUT = mem[ri];
                ri++;
                mcnt--;
            end
            if (BUF_RESET) begin
                rst_pulses++;
                wi = 0;
                ri = 0;
            end
            exp_cnt = CNT_W'(mcnt);
            exp_ww  = WORD_W'(wi / SYM_PER_WORD);
            exp_rw  = WORD_W'(ri / SYM_PER_WORD);
            chk("status_count_words_full_empty", {COUNT, WR_WORD, RD_WORD, FULL, EMPTY},
                {exp_cnt, exp_ww, exp_rw, (wi == CAPACITY), (mcnt == 0)});
            if (OUT_VALID && prev_ov && !prev_hs) chk("out_data_stable", OUT_DATA, prev_od);
            if (OUT_VALID && OUT_READY) begin
                if (oq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected data=0x%0h", OUT_DATA);
                end else begin
                    exp_sym = oq.pop_front();
                    chk("out_data", OUT_DATA, exp_sym);
                end
            end
            prev_ov = OUT_VALID;
            prev_od = OUT_DATA;
            prev_hs = OUT_VALID & OUT_READY;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic rdy);
        @(posedge CLOCK); #1;
        RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = rdy;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
    endtask

    task automatic write_sym(input logic [SYM_W-1:0] d);
        int n;
        @(posedge CLOCK); #1;
        IN_VALID = 1'b1; IN_DATA = d;
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!IN_READY && n < 50);
        if (!IN_READY) begin
            checks++; errors++;
            $display("FAIL write_timeout data=0x%0h", d);
        end
        @(posedge CLOCK); #1;
        IN_VALID = 1'b0;
    endtask

    typedef struct {
        logic [SYM_W-1:0]  data;
        int                n;
        logic              rdy;
        logic [CNT_W-1:0]  e_count;
        logic [WORD_W-1:0] e_wr;
        logic [WORD_W-1:0] e_rd;
        logic              e_ov;
        logic [SYM_W-1:0]  e_od;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        int sent;
        int guard;

        // With OUT_READY=0 exactly one read happens (OUT_VALID then sticks).
        tbl[0] = '{10'h2AB, 1, 1'b1, 7'd0, 5'd0, 5'd0, 1'b0, 10'h000};
        tbl[1] = '{10'h001, 3, 1'b1, 7'd0, 5'd1, 5'd1, 1'b0, 10'h000};
        tbl[2] = '{10'h3F0, 4, 1'b0, 7'd3, 5'd1, 5'd0, 1'b1, 10'h3F0};
        tbl[3] = '{10'h100, 5, 1'b1, 7'd0, 5'd1, 5'd1, 1'b0, 10'h000};
        tbl[4] = '{10'h0AA, 7, 1'b0, 7'd6, 5'd2, 5'd0, 1'b1, 10'h0AA};
        tbl[5] = '{10'h200, 2, 1'b0, 7'd1, 5'd0, 5'd0, 1'b1, 10'h200};

        // Reset state.
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("reset_state",
            {IN_READY, OUT_VALID, OUT_DATA, BUF_WRITE, BUF_READ, BUF_RESET,
             BUF_DATA_IN, COUNT, WR_WORD, RD_WORD, FULL, EMPTY}, 64'h1);

        // First write: IN_READY in c1, BUF_WRITE with data in c2.
        do_reset(1'b1);
        IN_VALID = 1'b1; IN_DATA = 10'h2AB;
        @(negedge CLOCK);
        chk("first_in_ready_c1", IN_READY, 1'b1);
        @(negedge CLOCK);
        chk("first_buf_write_c2", BUF_WRITE, 1'b1);
        chk("first_buf_data_in", BUF_DATA_IN, 10'h2AB);
        chk("first_count", COUNT, 7'd1);
        chk("first_empty", EMPTY, 1'b0);
        chk("in_ready_low_in_wr_busy", IN_READY, 1'b0);
        @(posedge CLOCK); #1 IN_VALID = 1'b0;
        repeat (15) @(posedge CLOCK);

        // Table-driven bursts.
        for (int i = 0; i < 6; i++) begin
            do_reset(tbl[i].rdy);
            for (int k = 0; k < tbl[i].n; k++) write_sym(tbl[i].data + SYM_W'(k));
            repeat (40) @(posedge CLOCK);
            @(negedge CLOCK);
            chk($sformatf("vec%0d_count", i), COUNT, tbl[i].e_count);
            chk($sformatf("vec%0d_wr_word", i), WR_WORD, tbl[i].e_wr);
            chk($sformatf("vec%0d_rd_word", i), RD_WORD, tbl[i].e_rd);
            chk($sformatf("vec%0d_out_valid", i), OUT_VALID, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), OUT_DATA, tbl[i].e_od);
        end

        // Alternating grants with IN_VALID held and the reader always ready.
        do_reset(1'b1);
        alt_pulses = 0;
        alt_on = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 10'h300;
        sent = 0; guard = 0;
        while (sent < 8 && guard < 400) begin
            @(negedge CLOCK);
            guard++;
            if (IN_READY) begin
                sent++;
                @(posedge CLOCK); #1;
                IN_DATA = IN_DATA + 10'd1;
            end
        end
        IN_VALID = 1'b0;
        chk("alt_symbols_sent", sent, 8);
        repeat (30) @(posedge CLOCK);
        chk("alt_pulse_total", alt_pulses, 16);
        alt_on = 1'b0;

        // Read latency: BUF_READ to OUT_VALID is RD_OP_CYCLES cycles.
        do_reset(1'b1);
        write_sym(10'h155);
        n = 0;
        do begin @(negedge CLOCK); n++; end while (!BUF_READ && n < 20);
        chk("latency_buf_read_seen", BUF_READ, 1'b1);
        n = 0;
        do begin @(negedge CLOCK); n++; end while (!OUT_VALID && n < 10);
        chk("read_latency", n, RD_OP_CYCLES);
        chk("read_out_data_155", OUT_DATA, 10'h155);
        repeat (5) @(posedge CLOCK);

        // Fill every slot with the reader stalled.
        do_reset(1'b0);
        for (int k = 0; k < CAPACITY; k++) write_sym(SYM_W'(10'h040 + k));
        repeat (10) @(posedge CLOCK);
        #1 IN_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK);
            chk("full_in_ready_low", IN_READY, 1'b0);
        end
        chk("full_flag", FULL, 1'b1);
        chk("full_wr_word", WR_WORD, 5'd21);
        chk("full_count", COUNT, 7'd62);
        chk("full_out_valid", OUT_VALID, 1'b1);
        chk("full_out_data", OUT_DATA, 10'h040);
        @(posedge CLOCK); #1 IN_VALID = 1'b0;

        // Drain everything: a single rewind follows.
        rst_pulses = 0;
        OUT_READY = 1'b1;
        n = 0;
        do begin @(negedge CLOCK); n++; end while (!(rst_pulses > 0 && !OUT_VALID) && n < 3000);
        chk("drain_rewind_seen", (rst_pulses > 0), 1'b1);
        repeat (6) @(negedge CLOCK);
        chk("drain_rewind_pulses", rst_pulses, 1);
        chk("drain_wr_word", WR_WORD, 5'd0);
        chk("drain_rd_word", RD_WORD, 5'd0);
        chk("drain_full", FULL, 1'b0);
        chk("drain_empty", EMPTY, 1'b1);

        // Reset asserted while a read is in flight.
        do_reset(1'b1);
        write_sym(10'h0F0);
        n = 0;
        do begin @(negedge CLOCK); n++; end while (!BUF_READ && n < 20);
        chk("midread_buf_read_seen", BUF_READ, 1'b1);
        #1 RESET = 1'b1;
        #2;
        chk("reset_mid_read",
            {IN_READY, OUT_VALID, OUT_DATA, BUF_WRITE, BUF_READ, BUF_RESET,
             BUF_DATA_IN, COUNT, WR_WORD, RD_WORD, FULL, EMPTY}, 64'h1);
        @(posedge CLOCK); #1 RESET = 1'b0;
        repeat (8) @(negedge CLOCK);
        chk("after_reset_no_output", {OUT_VALID, COUNT}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
